eth_speed_ctrl: RTL and testbench
=================================

ETH_SPEED_CTRL -- requirements
Module: eth_speed_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  IDLE_GAP, 12, consecutive quiet cycles required before switching
  SETTLE_CYC, 1024, cycles held after switching before release
  DRAIN_TMO, 16384, maximum DRAIN cycles before forced switch
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk_125M  in  1  sole clock; all logic on rising edge
  rst  in  1  synchronous active-high reset
  link_up  in  1  PHY link status, already in clk_125M domain
  speed_vld  in  1  single-cycle strobe qualifying speed_req
  speed_req  in  2  requested speed: 00=10M, 01=100M, 10=1000M, 11=reserved
  gm_tx_en  in  1  MAC transmit activity, clk_125M domain
  rx_dv  in  1  PHY receive valid, asynchronous (rx_clk domain)
  eth_mode  out  1  1=GMII, 0=MII, to GMII/MII mux and MAC
  ena_10  out  1  1=10M operation, to MAC
  tx_hold  out  1  requests MAC to stop starting frames
  cur_speed  out  2  currently applied speed code
  busy  out  1  high in any state other than IDLE
  done  out  1  single-cycle pulse when a switch completes
  req_err  out  1  single-cycle pulse on reserved speed_req
  drain_tmo  out  1  single-cycle pulse when DRAIN timed out

Function
REQ-003 rx_dv SHALL pass through a 2-flop synchronizer before use; gm_tx_en SHALL be used directly.
REQ-004 FSM states SHALL be LINK_DOWN, IDLE, DRAIN, SWITCH, SETTLE.
REQ-005 In any state, link_up=0 SHALL move to LINK_DOWN next cycle, aborting any switch; eth_mode, ena_10, cur_speed unchanged; pending request cleared.
REQ-006 LINK_DOWN: tx_hold=1; link_up=1 -> IDLE.
REQ-007 IDLE: tx_hold=0; a valid request differing from cur_speed -> DRAIN; equal request SHALL be ignored (no done pulse).
REQ-008 speed_vld with speed_req=11 SHALL pulse req_err next cycle and otherwise be ignored in every state.
REQ-009 DRAIN: tx_hold=1; quiet counter increments each cycle gm_tx_en=0 and synchronized rx_dv=0, clears to 0 otherwise; counter reaching IDLE_GAP -> SWITCH.
REQ-010 DRAIN cycle counter reaching DRAIN_TMO -> SWITCH with drain_tmo pulsed once.
REQ-011 SWITCH (one cycle): cur_speed<=target; eth_mode<=(target==10); ena_10<=(target==00); -> SETTLE.
REQ-012 SETTLE: tx_hold=1 for exactly SETTLE_CYC cycles, then done pulses on the transition to IDLE.
REQ-013 Valid requests during DRAIN/SWITCH/SETTLE SHALL be stored in a one-deep pending register, latest wins; target of an in-progress switch is not altered.
REQ-014 On entering IDLE with a pending request differing from cur_speed, FSM SHALL go directly to DRAIN the following cycle; matching pending request is discarded.
REQ-015 A request arriving in IDLE in the same cycle as link_up falls SHALL be dropped (REQ-005 wins).
REQ-016 Counters SHALL be sized by $clog2 of their parameter +1 and saturate, never wrap.
REQ-017 Outputs eth_mode, ena_10, tx_hold, cur_speed SHALL be registered; no combinational input-to-output path.

Reset
REQ-018 On rst=1 at a clock edge: state=LINK_DOWN, eth_mode=1, ena_10=0, cur_speed=10, tx_hold=1, busy=1, done=0, req_err=0, drain_tmo=0, counters and pending register cleared, synchronizer flops 0.
REQ-019 rst SHALL override all other inputs including mid-switch activity.

Structure
REQ-020 Speed code constants (SPD_10M, SPD_100M, SPD_1G, SPD_RSVD) and FSM state encoding SHALL live in the shared package eth_pkg.
REQ-021 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset to 0), instanced once.

Verification
REQ-022 Benches SHALL use IDLE_GAP=4, SETTLE_CYC=8, DRAIN_TMO=64 and cover:
  - rst, link_up=1, speed_req=01 in IDLE, idle bus -> eth_mode=0, ena_10=0, cur_speed=01, done 1+4+1+8 cycles after request (+/-1 per state boundary as defined).
  - gm_tx_en high 20 cycles after request -> no SWITCH until 4 quiet cycles after gm_tx_en falls; tx_hold=1 throughout.
  - gm_tx_en stuck high -> drain_tmo pulse at DRAIN cycle 64, speed applied, done after 8 settle cycles.
  - Requests 00 then 10 during SETTLE of switch to 01 -> done for 01, then second switch to 10 only (eth_mode=1, ena_10=0); 00 never applied.
  - link_up dropped in DRAIN -> LINK_DOWN next cycle, cur_speed unchanged, no done; speed_req=11 anywhere -> req_err single pulse.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared speed codes and controller state encoding for the Ethernet speed-change logic.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package eth_pkg;

    localparam logic [1:0] SPD_10M  = 2'b00;
    localparam logic [1:0] SPD_100M = 2'b01;
    localparam logic [1:0] SPD_1G   = 2'b10;
    localparam logic [1:0] SPD_RSVD = 2'b11;

    typedef enum logic [2:0] {
        LINK_DOWN = 3'd0,
        IDLE      = 3'd1,
        DRAIN     = 3'd2,
        SWITCH    = 3'd3,
        SETTLE    = 3'd4
    } state_t;

    // Any code other than the reserved one names a real speed
    function automatic logic spd_valid(input logic [1:0] spd);
        return spd != SPD_RSVD;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into clk_125M.
// Latency: two clk_125M cycles.
// Backpressure: none; free-running.
module sync_2ff (
    input  logic clk_125M,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both cleared on reset
    always_ff @(posedge clk_125M) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/eth_speed_ctrl.sv
// Speed-change sequencer: drains MAC/PHY traffic, applies the new MII/GMII speed, then holds for settling.
// Latency: request to done is at least IDLE_GAP quiet cycles + 1 switch cycle + SETTLE_CYC cycles.
// Backpressure: tx_hold asks the MAC to stop starting frames; requests arriving mid-switch queue one deep.
module eth_speed_ctrl
    import eth_pkg::*;
#(
    parameter int IDLE_GAP   = 12,
    parameter int SETTLE_CYC = 1024,
    parameter int DRAIN_TMO  = 16384
) (
    input  logic       clk_125M,
    input  logic       rst,
    input  logic       link_up,
    input  logic       speed_vld,
    input  logic [1:0] speed_req,
    input  logic       gm_tx_en,
    input  logic       rx_dv,
    output logic       eth_mode,
    output logic       ena_10,
    output logic       tx_hold,
    output logic [1:0] cur_speed,
    output logic       busy,
    output logic       done,
    output logic       req_err,
    output logic       drain_tmo
);

    localparam int QW = $clog2(IDLE_GAP) + 1;
    localparam int SW = $clog2(SETTLE_CYC) + 1;
    localparam int DW = $clog2(DRAIN_TMO) + 1;

    // A counter sitting at its LAST value moves the FSM on the next edge
    localparam logic [QW-1:0] Q_LAST = QW'(IDLE_GAP - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_TMO - 1);

    state_t        state_q;
    state_t        state_d;
    logic [QW-1:0] quiet_cnt;
    logic [SW-1:0] settle_cnt;
    logic [DW-1:0] drain_cnt;
    logic [1:0]    target_q;
    logic [1:0]    pend_spd;
    logic          pend_vld;
    logic [1:0]    eff_spd;
    logic          eff_vld;
    logic          req_ok;
    logic          req_bad;
    logic          rx_dv_s;
    logic          quiet;
    logic          tmo_fire;

    sync_2ff u_rx_sync (
        .clk_125M (clk_125M),
        .rst      (rst),
        .d        (rx_dv),
        .q        (rx_dv_s)
    );

    assign req_ok  = speed_vld && spd_valid(speed_req);
    assign req_bad = speed_vld && !spd_valid(speed_req);
    assign quiet   = !gm_tx_en && !rx_dv_s;
    // In IDLE a fresh request supersedes whatever was queued during the last switch
    assign eff_vld = req_ok || pend_vld;
    assign eff_spd = req_ok ? speed_req : pend_spd;
    assign busy    = (state_q != IDLE);

    // Next-state selection; losing the link overrides every other condition
    always_comb begin
        state_d  = state_q;
        tmo_fire = 1'b0;
        if (!link_up) begin
            state_d = LINK_DOWN;
        end else begin
            case (state_q)
                LINK_DOWN: state_d = IDLE;
                IDLE: begin
                    if (eff_vld && (eff_spd != cur_speed)) state_d = DRAIN;
                end
                DRAIN: begin
                    if (quiet && (quiet_cnt == Q_LAST)) begin
                        state_d = SWITCH;
                    end else if (drain_cnt == D_LAST) begin
                        state_d  = SWITCH;
                        tmo_fire = 1'b1;
                    end
                end
                SWITCH: state_d = SETTLE;
                SETTLE: begin
                    if (settle_cnt == S_LAST) state_d = IDLE;
                end
                default: state_d = LINK_DOWN;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_125M) begin
        if (rst) state_q <= LINK_DOWN;
        else     state_q <= state_d;
    end

    // Saturating per-state counters, held at zero outside the state they time
    always_ff @(posedge clk_125M) begin
        if (rst) begin
            quiet_cnt  <= '0;
            drain_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            if (state_q == DRAIN && quiet)
                quiet_cnt <= (quiet_cnt == '1) ? quiet_cnt : quiet_cnt + QW'(1);
            else
                quiet_cnt <= '0;
            if (state_q == DRAIN)
                drain_cnt <= (drain_cnt == '1) ? drain_cnt : drain_cnt + DW'(1);
            else
                drain_cnt <= '0;
            if (state_q == SETTLE)
                settle_cnt <= (settle_cnt == '1) ? settle_cnt : settle_cnt + SW'(1);
            else
                settle_cnt <= '0;
        end
    end

    // Target of the switch in flight, and the one-deep queue of later requests
    always_ff @(posedge clk_125M) begin
        if (rst) begin
            target_q <= SPD_1G;
            pend_vld <= 1'b0;
            pend_spd <= SPD_10M;
        end else begin
            if (state_q == IDLE && state_d == DRAIN) target_q <= eff_spd;
            if (!link_up || state_q == IDLE) begin
                pend_vld <= 1'b0;
            end else if (req_ok && (state_q inside {DRAIN, SWITCH, SETTLE})) begin
                pend_vld <= 1'b1;
                pend_spd <= speed_req;
            end
        end
    end

    // Registered outputs; speed settings only change on a completed SWITCH cycle
    always_ff @(posedge clk_125M) begin
        if (rst) begin
            cur_speed <= SPD_1G;
            eth_mode  <= 1'b1;
            ena_10    <= 1'b0;
            tx_hold   <= 1'b1;
            done      <= 1'b0;
            req_err   <= 1'b0;
            drain_tmo <= 1'b0;
        end else begin
            tx_hold   <= (state_d != IDLE);
            done      <= (state_q == SETTLE) && (state_d == IDLE);
            req_err   <= req_bad;
            drain_tmo <= tmo_fire;
            if (state_q == SWITCH && link_up) begin
                cur_speed <= target_q;
                eth_mode  <= (target_q == SPD_1G);
                ena_10    <= (target_q == SPD_10M);
            end
        end
    end

endmodule

// File: tb/tb_eth_speed_ctrl.sv
// Self-checking bench for eth_speed_ctrl: directed vector table, corner sequences, random traffic vs model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_eth_speed_ctrl;

    localparam int GAP = 4;
    localparam int SET = 8;
    localparam int TMO = 64;

    logic       clk_125M = 1'b0;
    logic       rst = 1'b1;
    logic       link_up = 1'b0;
    logic       speed_vld = 1'b0;
    logic [1:0] speed_req = 2'b00;
    logic       gm_tx_en = 1'b0;
    logic       rx_dv = 1'b0;
    logic       eth_mode, ena_10, tx_hold, busy, done, req_err, drain_tmo;
    logic [1:0] cur_speed;

    int n_cmp = 0;
    int n_bad = 0;

    eth_speed_ctrl #(.IDLE_GAP(GAP), .SETTLE_CYC(SET), .DRAIN_TMO(TMO)) dut (
        .clk_125M  (clk_125M),
        .rst       (rst),
        .link_up   (link_up),
        .speed_vld (speed_vld),
        .speed_req (speed_req),
        .gm_tx_en  (gm_tx_en),
        .rx_dv     (rx_dv),
        .eth_mode  (eth_mode),
        .ena_10    (ena_10),
        .tx_hold   (tx_hold),
        .cur_speed (cur_speed),
        .busy      (busy),
        .done      (done),
        .req_err   (req_err),
        .drain_tmo (drain_tmo)
    );

    always #4 clk_125M = ~clk_125M;

    // Reference model: phase name plus countdowns of what is still owed
    string      m_phase = "down";
    logic [1:0] m_cur = 2'b10;
    logic [1:0] m_tgt = 2'b00;
    logic [1:0] m_pend = 2'b00;
    bit         m_pend_v = 1'b0;
    int         m_quiet_need = 0;
    int         m_drain_left = 0;
    int         m_settle_left = 0;
    bit         m_done = 1'b0;
    bit         m_err = 1'b0;
    bit         m_tmo = 1'b0;
    bit [1:0]   m_rx = 2'b00;

    function automatic logic [8:0] dut_vec();
        return {cur_speed, eth_mode, ena_10, tx_hold, busy, done, req_err, drain_tmo};
    endfunction

    function automatic logic [8:0] model_vec();
        logic idle;
        idle = (m_phase == "idle");
        return {m_cur, (m_cur == 2'b10), (m_cur == 2'b00), !idle, !idle, m_done, m_err, m_tmo};
    endfunction

    task automatic model_step(input bit r, input bit lu, input bit vld, input logic [1:0] req,
                              input bit tx, input bit rx);
        bit rx_seen;
        bit good;
        if (r) begin
            m_phase = "down"; m_cur = 2'b10; m_pend_v = 1'b0; m_pend = 2'b00; m_tgt = 2'b00;
            m_rx = 2'b00; m_done = 1'b0; m_err = 1'b0; m_tmo = 1'b0;
            return;
        end
        rx_seen = m_rx[1];
        m_rx    = {m_rx[0], rx};
        good    = vld && (req != 2'b11);
        m_err   = vld && (req == 2'b11);
        m_done  = 1'b0;
        m_tmo   = 1'b0;
        if (!lu) begin
            m_phase  = "down";
            m_pend_v = 1'b0;
        end else if (m_phase == "down") begin
            m_phase = "idle";
        end else if (m_phase == "idle") begin
            if (good) begin m_pend_v = 1'b1; m_pend = req; end
            if (m_pend_v && m_pend != m_cur) begin
                m_tgt = m_pend; m_phase = "drain"; m_quiet_need = GAP; m_drain_left = TMO;
            end
            m_pend_v = 1'b0;
        end else begin
            if (good) begin m_pend_v = 1'b1; m_pend = req; end
            if (m_phase == "drain") begin
                m_drain_left--;
                m_quiet_need = (!tx && !rx_seen) ? m_quiet_need - 1 : GAP;
                if (m_quiet_need == 0) m_phase = "switch";
                else if (m_drain_left == 0) begin m_phase = "switch"; m_tmo = 1'b1; end
            end else if (m_phase == "switch") begin
                m_cur = m_tgt; m_phase = "settle"; m_settle_left = SET;
            end else begin
                m_settle_left--;
                if (m_settle_left == 0) begin m_phase = "idle"; m_done = 1'b1; end
            end
        end
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cur,mode,ena10,hold,busy,done,err,tmo) t=%0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 ns later
    task automatic step(input bit r, input bit lu, input bit vld, input logic [1:0] req,
                        input bit tx, input bit rx);
        rst = r; link_up = lu; speed_vld = vld; speed_req = req; gm_tx_en = tx; rx_dv = rx;
        @(posedge clk_125M);
        model_step(r, lu, vld, req, tx, rx);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    typedef struct {
        int         reps;
        bit         r, lu, vld;
        logic [1:0] req;
        bit         tx, rx;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int  got, n, tmo_at, tmo_cnt, done_at, dones, d1_t, d2_t, busy_seen, done_seen;
        bit  hold_ok, saw_zero;
        logic [1:0] d1_cur, d2_cur;
        logic [1:0] rq;
        bit  r_r, r_lu, r_v, r_rx, tx_lvl;
        int  burst;

        // Basic switch 1G -> 100M on an idle bus, then equal and reserved requests
        tbl[0]  = '{2, 1, 1, 0, 2'b00, 0, 0, 9'b10_1_0_1_1_0_0_0};
        tbl[1]  = '{1, 0, 1, 0, 2'b00, 0, 0, 9'b10_1_0_0_0_0_0_0};
        tbl[2]  = '{1, 0, 1, 1, 2'b01, 0, 0, 9'b10_1_0_1_1_0_0_0};
        tbl[3]  = '{4, 0, 1, 0, 2'b00, 0, 0, 9'b10_1_0_1_1_0_0_0};
        tbl[4]  = '{8, 0, 1, 0, 2'b00, 0, 0, 9'b01_0_0_1_1_0_0_0};
        tbl[5]  = '{1, 0, 1, 0, 2'b00, 0, 0, 9'b01_0_0_0_0_1_0_0};
        tbl[6]  = '{1, 0, 1, 0, 2'b00, 0, 0, 9'b01_0_0_0_0_0_0_0};
        tbl[7]  = '{1, 0, 1, 1, 2'b01, 0, 0, 9'b01_0_0_0_0_0_0_0};
        tbl[8]  = '{1, 0, 1, 0, 2'b00, 0, 0, 9'b01_0_0_0_0_0_0_0};
        tbl[9]  = '{1, 0, 1, 1, 2'b11, 0, 0, 9'b01_0_0_0_0_0_1_0};
        tbl[10] = '{1, 0, 1, 0, 2'b00, 0, 0, 9'b01_0_0_0_0_0_0_0};

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < tbl[i].reps; k++) begin
                step(tbl[i].r, tbl[i].lu, tbl[i].vld, tbl[i].req, tbl[i].tx, tbl[i].rx);
                check($sformatf("table row %0d rep %0d", i, k), dut_vec(), tbl[i].exp);
            end
        end

        // MAC busy for 20 cycles after a request to 1G: switch waits for 4 quiet cycles
        step(0, 1, 1, 2'b10, 1, 0);
        hold_ok = 1'b1;
        for (int i = 1; i < 20; i++) begin
            step(0, 1, 0, 2'b00, 1, 0);
            hold_ok &= tx_hold;
        end
        got = -1;
        for (int i = 20; i <= 40 && got < 0; i++) begin
            step(0, 1, 0, 2'b00, 0, 0);
            if (cur_speed == 2'b10) got = i;
            else hold_ok &= tx_hold;
        end
        check_int("busy mac switch edge", got, 24);
        check_int("busy mac tx_hold", int'(hold_ok), 1);
        n = -1;
        for (int i = 1; i <= 20 && n < 0; i++) begin
            step(0, 1, 0, 2'b00, 0, 0);
            if (done) n = i;
        end
        check_int("busy mac done delay", n, SET);

        // MAC stuck high: forced switch to 10M on drain timeout
        step(0, 1, 1, 2'b00, 1, 0);
        tmo_at = -1; tmo_cnt = 0; done_at = -1;
        for (int i = 1; i <= 100 && done_at < 0; i++) begin
            step(0, 1, 0, 2'b00, 1, 0);
            if (drain_tmo) begin tmo_cnt++; if (tmo_at < 0) tmo_at = i; end
            if (done) done_at = i;
        end
        check_int("timeout pulse cycle", tmo_at, TMO);
        check_int("timeout pulse count", tmo_cnt, 1);
        check_int("timeout done cycle", done_at, TMO + 1 + SET);
        check_int("timeout cur_speed", int'(cur_speed), 0);
        check_int("timeout ena_10", int'(ena_10), 1);
        step(0, 1, 0, 2'b00, 0, 0);

        // Requests 00 then 10 during SETTLE of a switch to 01: only 01 then 10 are applied
        step(0, 1, 1, 2'b01, 0, 0);
        repeat (5) step(0, 1, 0, 2'b00, 0, 0);
        step(0, 1, 0, 2'b00, 0, 0);
        step(0, 1, 1, 2'b00, 0, 0);
        step(0, 1, 0, 2'b00, 0, 0);
        step(0, 1, 1, 2'b10, 0, 0);
        dones = 0; d1_t = -1; d2_t = -1; d1_cur = 2'b11; d2_cur = 2'b11; saw_zero = 1'b0;
        for (int t = 10; t <= 80 && dones < 2; t++) begin
            step(0, 1, 0, 2'b00, 0, 0);
            if (cur_speed == 2'b00) saw_zero = 1'b1;
            if (done) begin
                dones++;
                if (dones == 1) begin d1_t = t; d1_cur = cur_speed; end
                else begin d2_t = t; d2_cur = cur_speed; end
            end
        end
        check_int("queued first done cycle", d1_t, 13);
        check_int("queued first speed", int'(d1_cur), 1);
        check_int("queued second done cycle", d2_t, 27);
        check_int("queued second speed", int'(d2_cur), 2);
        check_int("queued eth_mode", int'(eth_mode), 1);
        check_int("queued ena_10", int'(ena_10), 0);
        check_int("queued 10M never applied", int'(saw_zero), 0);

        // Link lost during DRAIN, reserved request while down
        step(0, 1, 1, 2'b01, 0, 0);
        repeat (2) step(0, 1, 0, 2'b00, 0, 0);
        step(0, 0, 0, 2'b00, 0, 0);
        check("link drop in drain", dut_vec(), 9'b10_1_0_1_1_0_0_0);
        done_seen = 0;
        step(0, 0, 1, 2'b11, 0, 0);
        check_int("req_err while down", int'(req_err), 1);
        step(0, 0, 0, 2'b00, 0, 0);
        check_int("req_err single pulse", int'(req_err), 0);
        step(0, 1, 0, 2'b00, 0, 0);
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 2'b00, 0, 0);
            busy_seen += int'(busy);
            done_seen += int'(done);
        end
        check_int("aborted switch stays idle", busy_seen, 0);
        check_int("aborted switch no done", done_seen, 0);
        check_int("aborted switch speed kept", int'(cur_speed), 2);

        // Request in IDLE in the same cycle link falls is dropped
        step(0, 0, 1, 2'b00, 0, 0);
        step(0, 1, 0, 2'b00, 0, 0);
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 2'b00, 0, 0);
            busy_seen += int'(busy);
        end
        check_int("request with link fall dropped", busy_seen, 0);

        // Random traffic against the model
        burst = 0; tx_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r_r  = ($urandom_range(0, 999) == 0);
            r_lu = ($urandom_range(0, 299) != 0);
            r_v  = ($urandom_range(0, 11) == 0);
            rq   = 2'($urandom_range(0, 3));
            r_rx = ($urandom_range(0, 7) == 0);
            if (burst == 0) begin
                tx_lvl = ($urandom_range(0, 2) == 0);
                burst  = (tx_lvl && $urandom_range(0, 9) == 0) ? int'($urandom_range(30, 90))
                                                                : int'($urandom_range(1, 6));
            end
            burst--;
            step(r_r, r_lu, r_v, rq, tx_lvl, r_rx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
